sc_speed_scheduler: RTL and testbench

Multi-lane speed scheduler for the Frogger playfield. Generates one-clock shift pulses per lane (car/log rows) at a rate set by an 8-bit speed value per lane. Each lane has its own down-counter with zero detection, the same "register equals zero" function used by the speed comparators. Sits between the game-level logic, which writes the speeds and starts, pauses or stops play, and the lane shift registers, which consume the pulses.

---
 rtl/sc_speed_pkg.sv | 27 ++
 rtl/sc_speed_scheduler_lane.sv | 54 +++++
 rtl/sc_speed_scheduler.sv | 116 +++++++++++
 tb/tb_sc_speed_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_speed_pkg.sv
// Shared types and constants for the Frogger lane speed scheduler.
// Holds the state encoding, speed width and the write request record.
package sc_speed_pkg;

    localparam int SPEED_W = 8;
    localparam logic [SPEED_W-1:0] SPEED_OFF = 8'h00;
    localparam logic [SPEED_W-1:0] SPEED_ONE = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } schedState_t;

    typedef struct packed {
        logic               vld;
        logic [2:0]         lane;
        logic [SPEED_W-1:0] data;
    } speedWr_t;

    // Same "register equals zero" test used by counters and speed checks.
    function automatic logic isZero(input logic [SPEED_W-1:0] v);
        return v == SPEED_OFF;
    endfunction

endpackage

// File: rtl/sc_speed_scheduler_lane.sv
// One lane: down-counter, arm flag, zero detect and registered fire pulse.
// speed is the effective value, so a same-edge write is seen by the reload.
module sc_lane_counter
    import sc_speed_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               tick,
    input  logic               wrArm,
    input  logic [SPEED_W-1:0] speed,
    output logic               fire
);

    logic [SPEED_W-1:0] cnt;
    logic [SPEED_W-1:0] reloadVal;
    logic               armed;
    logic               cntZero;
    logic               speedOn;

    assign cntZero   = isZero(cnt);
    assign speedOn   = !isZero(speed);
    assign reloadVal = speedOn ? speed - SPEED_ONE : SPEED_OFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= SPEED_OFF;
            armed <= 1'b0;
            fire  <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (clear) begin
                armed <= 1'b0;
            end else if (load) begin
                cnt   <= reloadVal;
                armed <= speedOn;
            end else if (tick && armed) begin
                if (cntZero) begin
                    fire  <= 1'b1;
                    cnt   <= reloadVal;
                    armed <= speedOn;
                end else begin
                    cnt <= cnt - SPEED_ONE;
                end
            // Armed lanes ignore writes until their next reload.
            end else if (wrArm && !armed) begin
                cnt   <= reloadVal;
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_speed_scheduler.sv
// Lane speed scheduler top: play FSM, base-tick prescaler, speed registers
// and write decode, feeding one sc_lane_counter per lane.
module sc_speed_scheduler
    import sc_speed_pkg::*;
#(
    parameter int                        LANES          = 4,
    parameter int                        PRESCALE_WIDTH = 23,
    parameter logic [PRESCALE_WIDTH-1:0] PRESCALE_MAX   = 23'd4_999_999
) (
    input  logic             SC_SPEEDSCHEDULER_CLOCK_50,
    input  logic             SC_SPEEDSCHEDULER_RESET_InHigh,
    input  logic             SC_SPEEDSCHEDULER_start_InHigh,
    input  logic             SC_SPEEDSCHEDULER_pause_InHigh,
    input  logic             SC_SPEEDSCHEDULER_stop_InHigh,
    input  logic             SC_SPEEDSCHEDULER_wr_InHigh,
    input  logic [2:0]       SC_SPEEDSCHEDULER_wrLane_InBUS,
    input  logic [7:0]       SC_SPEEDSCHEDULER_wrData_InBUS,
    output logic [LANES-1:0] SC_SPEEDSCHEDULER_shift_OutBUS,
    output logic [1:0]       SC_SPEEDSCHEDULER_state_OutBUS,
    output logic             SC_SPEEDSCHEDULER_tick_OutHigh
);

    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = 1;

    logic clk, rst, start, pause, stop;
    assign clk   = SC_SPEEDSCHEDULER_CLOCK_50;
    assign rst   = SC_SPEEDSCHEDULER_RESET_InHigh;
    assign start = SC_SPEEDSCHEDULER_start_InHigh;
    assign pause = SC_SPEEDSCHEDULER_pause_InHigh;
    assign stop  = SC_SPEEDSCHEDULER_stop_InHigh;

    schedState_t               state, stateNxt;
    logic [PRESCALE_WIDTH-1:0] presc, prescNxt;
    logic [LANES-1:0][SPEED_W-1:0] speed, speedEff;
    logic [LANES-1:0]          laneWr;
    logic [LANES-1:0]          fire;
    speedWr_t                  wrReq;
    logic                      tickNow, laneTick, laneClear, laneLoad, wrArmOk;
    logic                      tickQ;

    assign wrReq.vld  = SC_SPEEDSCHEDULER_wr_InHigh;
    assign wrReq.lane = SC_SPEEDSCHEDULER_wrLane_InBUS;
    assign wrReq.data = SC_SPEEDSCHEDULER_wrData_InBUS;

    assign tickNow   = (state == RUN) && (presc == PRESCALE_MAX);
    // A stop on a tick cycle wins: no counter step and no pulse.
    assign laneTick  = tickNow && !stop;
    assign laneClear = (state == IDLE) || stop;
    assign laneLoad  = (state == LOAD);
    assign wrArmOk   = ((state == RUN) || (state == PAUSE)) && !isZero(wrReq.data);

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = LOAD;
            LOAD:    stateNxt = RUN;
            RUN:     if (pause) stateNxt = PAUSE;
            PAUSE:   if (start) stateNxt = RUN;
            default: stateNxt = IDLE;
        endcase
        if (stop) stateNxt = IDLE;
    end

    always_comb begin
        prescNxt = presc;
        case (state)
            IDLE, LOAD: prescNxt = '0;
            RUN:        prescNxt = tickNow ? '0 : presc + PRESC_ONE;
            default:    prescNxt = presc;
        endcase
        if (stop) prescNxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            tickQ <= 1'b0;
        end else begin
            state <= stateNxt;
            presc <= prescNxt;
            tickQ <= laneTick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed <= '0;
        end else begin
            for (int i = 0; i < LANES; i++)
                if (laneWr[i]) speed[i] <= wrReq.data;
        end
    end

    // Indices >= LANES match no lane, so those writes fall away.
    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
        assign laneWr[gi]   = wrReq.vld && (wrReq.lane == 3'(gi));
        assign speedEff[gi] = laneWr[gi] ? wrReq.data : speed[gi];

        sc_lane_counter uLane (
            .clk   (clk),
            .rst   (rst),
            .clear (laneClear),
            .load  (laneLoad),
            .tick  (laneTick),
            .wrArm (laneWr[gi] && wrArmOk),
            .speed (speedEff[gi]),
            .fire  (fire[gi])
        );
    end

    assign SC_SPEEDSCHEDULER_shift_OutBUS = fire;
    assign SC_SPEEDSCHEDULER_state_OutBUS = state;
    assign SC_SPEEDSCHEDULER_tick_OutHigh = tickQ;

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Directed bench for sc_speed_scheduler with a 4-clock base tick and 4 lanes.
// Samples and drives on the falling edge; n counts rising edges since RUN entry.
module tb_sc_speed_scheduler;

    localparam int LANES = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0, pause = 1'b0, stop = 1'b0, wr = 1'b0;
    logic [2:0]       wrLane = '0;
    logic [7:0]       wrData = '0;
    logic [LANES-1:0] shift;
    logic [1:0]       state;
    logic             tick;

    int nChk = 0;
    int nFail = 0;
    int cnt [LANES];

    always #5 clk = ~clk;

    sc_speed_scheduler #(
        .LANES          (LANES),
        .PRESCALE_WIDTH (23),
        .PRESCALE_MAX   (23'd3)
    ) dut (
        .SC_SPEEDSCHEDULER_CLOCK_50     (clk),
        .SC_SPEEDSCHEDULER_RESET_InHigh (rst),
        .SC_SPEEDSCHEDULER_start_InHigh (start),
        .SC_SPEEDSCHEDULER_pause_InHigh (pause),
        .SC_SPEEDSCHEDULER_stop_InHigh  (stop),
        .SC_SPEEDSCHEDULER_wr_InHigh    (wr),
        .SC_SPEEDSCHEDULER_wrLane_InBUS (wrLane),
        .SC_SPEEDSCHEDULER_wrData_InBUS (wrData),
        .SC_SPEEDSCHEDULER_shift_OutBUS (shift),
        .SC_SPEEDSCHEDULER_state_OutBUS (state),
        .SC_SPEEDSCHEDULER_tick_OutHigh (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wrSpd(input logic [2:0] lane, input logic [7:0] data);
        wr = 1'b1; wrLane = lane; wrData = data;
        cyc();
        wr = 1'b0;
    endtask

    task automatic doStop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stopIdle", state, 0);
    endtask

    // Leaves the bench at the sample just after the RUN-entry edge (n = 0).
    task automatic goRun();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("stLoad", state, 1);
        cyc();
        chk("stRun", state, 2);
        chk("shiftRun0", shift, 0);
    endtask

    initial begin
        // Reset state
        cyc();
        chk("rstState", state, 0);
        chk("rstShift", shift, 0);
        chk("rstTick", tick, 0);
        rst = 1'b0;
        cyc();
        chk("idleState", state, 0);

        // Basic period: lane0 = 2 -> pulse every 8 clocks, tick every 4
        wrSpd(0, 8'd2);
        goRun();
        for (int n = 1; n <= 24; n++) begin
            cyc();
            chk("basicShift", shift, (n % 8 == 0) ? 4'b0001 : 4'b0000);
            chk("basicTick", tick, (n % 4 == 0) ? 1 : 0);
        end

        // Mixed speeds over 48 clocks
        doStop();
        wrSpd(0, 8'd1);
        wrSpd(1, 8'd2);
        wrSpd(2, 8'd3);
        wrSpd(3, 8'd0);
        goRun();
        for (int i = 0; i < LANES; i++) cnt[i] = 0;
        for (int n = 1; n <= 48; n++) begin
            cyc();
            for (int i = 0; i < LANES; i++) cnt[i] += int'(shift[i]);
        end
        chk("mixLane0", cnt[0], 12);
        chk("mixLane1", cnt[1], 6);
        chk("mixLane2", cnt[2], 4);
        chk("mixLane3", cnt[3], 0);

        // Pause/resume with lane0 = 1
        doStop();
        wrSpd(1, 8'd0);
        wrSpd(2, 8'd0);
        goRun();
        repeat (6) cyc();
        pause = 1'b1;
        cyc();
        chk("pauseState", state, 3);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("pauseShift", shift, 0);
            chk("pauseTick", tick, 0);
        end
        pause = 1'b0; start = 1'b1;
        cyc();
        chk("resumeState", state, 2);
        chk("resumeShift", shift, 0);
        // Prescaler resumed at its last value: this cycle is a tick; pause on it
        start = 1'b0; pause = 1'b1;
        cyc();
        chk("pauseOnTickShift", shift, 4'b0001);
        chk("pauseOnTickTick", tick, 1);
        chk("pauseOnTickState", state, 3);
        pause = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume2State", state, 2);
        chk("resume2Shift", shift, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("resume2Gap", shift, (k == 4) ? 4'b0001 : 4'b0000);
        end

        // Live speed change; lane index 4 must not alias lane0
        doStop();
        wrSpd(0, 8'd2);
        wrSpd(4, 8'd1);
        goRun();
        for (int n = 1; n <= 58; n++) begin
            cyc();
            chk("liveShift", shift,
                (n == 8 || n == 16 || n == 44 || n == 56) ? 4'b0001 : 4'b0000);
            wr = (n == 10) || (n == 32);
            wrLane = 3'd0;
            wrData = (n == 10) ? 8'd0 : 8'd3;
        end
        wr = 1'b0;

        // Stop and start together in RUN -> IDLE, and stays there
        stop = 1'b1; start = 1'b1;
        cyc();
        stop = 1'b0; start = 1'b0;
        chk("stopStartState", state, 0);
        chk("stopStartShift", shift, 0);
        cyc();
        chk("stopStartHold", state, 0);

        // Write coinciding with a reload: new speed 1 applies at that reload
        wrSpd(0, 8'd2);
        goRun();
        for (int n = 1; n <= 20; n++) begin
            cyc();
            chk("reloadWrShift", shift, (n >= 8 && n % 4 == 0) ? 4'b0001 : 4'b0000);
            wr = (n == 7);
            wrLane = 3'd0;
            wrData = 8'd1;
        end
        wr = 1'b0;

        // Asynchronous reset while a pulse is high
        chk("preRstShift", shift, 4'b0001);
        #1 rst = 1'b1;
        #1;
        chk("asyncRstShift", shift, 0);
        chk("asyncRstTick", tick, 0);
        chk("asyncRstState", state, 0);
        cyc();
        rst = 1'b0;
        cyc();
        goRun();
        for (int n = 1; n <= 20; n++) begin
            cyc();
            chk("postRstShift", shift, 0);
            chk("postRstTick", tick, (n % 4 == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
